debug_wb_serializer: RTL and testbench
======================================

# debug_wb_serializer

Parametrised commit-trace serializer between a multi-issue core's writeback stage and the single-lane `debug_wb_*` trace ports of the CPU top.
- Each cycle it accepts up to `LANES` retiring instructions, oldest first.
- It buffers them in a circular FIFO of `DEPTH` entries.
- It presents them on the trace ports one per cycle, in program order.
- Unlike a direct wire-up of the writeback signals, it supports more than one commit per cycle, optionally filters commits that do not write the register file, and reports backpressure and overflow.

## Interface
Parameters:
- `LANES`, default 2: commit lanes per cycle, 1..4. Lane 0 is the oldest.
- `DEPTH`, default 8: FIFO entries. Must be a power of 2 and at least `LANES`.
- `DROP_NOWRITE`, default 1: when 1, a lane whose `wen` is 0 or whose `wnum` is 0 is discarded and uses no FIFO entry.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock.
- `resetn`  in  1  asynchronous active-low reset.
- `in_valid`  in  `LANES`  per-lane commit valid.
- `in_pc`  in  `LANES*32`  per-lane PC. Lane i occupies bits [32i+31:32i].
- `in_wen`  in  `LANES*4`  per-lane register-file byte write strobe.
- `in_wnum`  in  `LANES*5`  per-lane destination register index.
- `in_wdata`  in  `LANES*32`  per-lane write data.
- `in_ready`  out  1  high when all `LANES` lanes can be accepted this cycle.
- `debug_wb_pc`  out  32  presented PC.
- `debug_wb_rf_wen`  out  4  presented strobe. 0 means no entry this cycle.
- `debug_wb_rf_wnum`  out  5  presented register index.
- `debug_wb_rf_wdata`  out  32  presented write data.
- `occupancy`  out  `$clog2(DEPTH)+1`  current FIFO count.
- `overflow`  out  1  sticky; set when a commit is lost.

## Operation
- Storage is a circular buffer with read and write pointers of width `$clog2(DEPTH)` and a count register of width `$clog2(DEPTH)+1`. Both pointers wrap modulo `DEPTH`.
- Kept lanes:
  - A lane is kept when `in_valid[i]` is high.
  - If `DROP_NOWRITE`=1, it additionally needs `in_wen[i]` != 0 and `in_wnum[i]` != 0.
  - `n_push` is the number of kept lanes.
- `in_ready` = (`DEPTH` - count >= `LANES`). It is combinational from the registered count only. A pop in the same cycle does not raise it.
- Enqueue, when `in_ready` is high:
  - Kept lanes are compacted in ascending lane order.
  - They are written to consecutive slots starting at the write pointer.
  - The write pointer advances by `n_push`.
- Enqueue when `in_ready` is low and `n_push` > 0:
  - All lanes of that cycle are discarded.
  - `overflow` is set and stays high until reset.
  - FIFO contents and pointers are unchanged.
- Dequeue, every cycle with count > 0:
  - The head entry is loaded into the output registers.
  - The read pointer advances by 1.
- Dequeue, every cycle with count = 0:
  - The output registers load all zeros, so `wen`=0.
- Count update: count_next = count + (accepted ? `n_push` : 0) - (count>0 ? 1 : 0). Simultaneous push and pop are legal in any state, including one pop from full with `in_ready` low.
- The block has no output backpressure. Each entry is presented for exactly one cycle.

## Timing
- Reset values, applied asynchronously while `resetn` is low:
  - count, pointers, all `debug_wb_*` outputs, and `overflow` are 0.
  - `in_ready` is 1, because `DEPTH` >= `LANES`.
- Reset asserted mid-operation discards all buffered entries. Nothing buffered before reset is ever presented.
- Latency:
  - A commit sampled at rising edge t is written to the FIFO at edge t.
  - It is popped into the output registers no earlier than edge t+1.
  - It is visible on the `debug_wb_*` ports during cycle t+1. There is no bypass path.
- Throughput: one entry out per cycle. Sustained input must average at most 1 kept lane per cycle to avoid `in_ready` going low.
- Output `debug_wb_*` and `occupancy` are registered. `in_ready` and `overflow` follow registered state directly.

## Test plan
1. **Reset.** Hold `resetn`=0 with random inputs.
   - Required: all `debug_wb_*` = 0, `occupancy`=0, `overflow`=0, `in_ready`=1.
   - Release reset: the outputs stay 0.
2. **Single commit.** Lane 0 only: pc=0xbfc00000, wen=0xf, wnum=2, wdata=0x1234, valid for one cycle at edge t.
   - Required: exactly those values on the trace ports in the cycle after edge t+1, for one cycle.
   - Then `wen`=0.
3. **Dual commit ordering.** Lane 0 pc=0xbfc00010 and lane 1 pc=0xbfc00014 in the same cycle.
   - Required: 0xbfc00010, then 0xbfc00014, on consecutive cycles.
4. **Filtering**, `DROP_NOWRITE`=1. Lane 0 with wnum=0 and lane 1 with wnum=5, wen=0xf.
   - Required: only the lane 1 entry is presented; `occupancy` peaks at 1.
   - Repeat with `DROP_NOWRITE`=0: two entries are presented, the first with `wnum`=0.
5. **Saturation and wrap.** `LANES`=2, `DEPTH`=4, both lanes kept every cycle, with PCs incrementing by 4, for 20 cycles.
   - Required `occupancy` sequence: 0, 2, 3, 2, 3, …
   - Required `in_ready` pattern: 1, 1, 0, 1, 0, …
   - Every PC is presented in order with no gaps when the stimulus obeys `in_ready`.
   - A second run ignoring `in_ready` sets `overflow`=1 on the first blocked cycle. The dropped pair never appears.
6. **Reset mid-stream.** With 3 entries buffered, pulse `resetn` low between clock edges.
   - Required: outputs go to 0 immediately and `occupancy`=0.
   - None of the 3 entries appears after release.

Source files
------------

// File: rtl/debug_wb_serializer.sv
// Commit-trace serializer: accepts up to LANES retiring instructions per cycle into a
// circular FIFO and replays them one per cycle on the single-lane debug_wb_* trace ports.
module debug_wb_serializer #(
  parameter int LANES        = 2,
  parameter int DEPTH        = 8,
  parameter int DROP_NOWRITE = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [LANES-1:0]         in_valid,
  input  logic [LANES*32-1:0]      in_pc,
  input  logic [LANES*4-1:0]       in_wen,
  input  logic [LANES*5-1:0]       in_wnum,
  input  logic [LANES*32-1:0]      in_wdata,
  output logic                     in_ready,
  output logic [31:0]              debug_wb_pc,
  output logic [3:0]               debug_wb_rf_wen,
  output logic [4:0]               debug_wb_rf_wnum,
  output logic [31:0]              debug_wb_rf_wdata,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  entry_t          out_q, out_d;
  logic            overflow_q, overflow_d;

  entry_t          lane_entry [LANES];
  logic [LANES-1:0] keep;
  logic [PW-1:0]   slot [LANES];
  logic [CW-1:0]   n_push;
  logic            pop;

  // Kept lanes are compacted: each lands at wr_ptr plus the number of kept lanes below it.
  always_comb begin
    n_push = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_entry[i].pc    = in_pc[32*i +: 32];
      lane_entry[i].wen   = in_wen[4*i +: 4];
      lane_entry[i].wnum  = in_wnum[5*i +: 5];
      lane_entry[i].wdata = in_wdata[32*i +: 32];
      keep[i] = in_valid[i] &&
                ((DROP_NOWRITE == 0) ||
                 ((in_wen[4*i +: 4] != '0) && (in_wnum[5*i +: 5] != '0)));
      slot[i] = wr_ptr_q + n_push[PW-1:0];
      n_push  = n_push + CW'(keep[i]);
    end
  end

  // Driven from the registered count only, so a same-cycle pop never frees a slot early.
  assign in_ready = (count_q <= CW'(DEPTH - LANES));
  assign pop      = (count_q != '0);

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    out_d      = '0;
    overflow_d = overflow_q;
    if (in_ready) begin
      wr_ptr_d = wr_ptr_q + n_push[PW-1:0];
    end else if (n_push != '0) begin
      overflow_d = 1'b1;
    end
    if (pop) begin
      out_d    = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + (in_ready ? n_push : '0) - CW'(pop);
  end

  // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_q      <= out_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array is not reset; the pointers and count alone decide which
  // slots are valid, so stale contents are never presented.
  always_ff @(posedge clk) begin
    if (in_ready) begin
      for (int i = 0; i < LANES; i++) begin
        if (keep[i]) mem_q[slot[i]] <= lane_entry[i];
      end
    end
  end

  assign debug_wb_pc       = out_q.pc;
  assign debug_wb_rf_wen   = out_q.wen;
  assign debug_wb_rf_wnum  = out_q.wnum;
  assign debug_wb_rf_wdata = out_q.wdata;
  assign occupancy         = count_q;
  assign overflow          = overflow_q;

endmodule

// File: tb/tb_debug_wb_serializer.sv
// Scoreboard bench for debug_wb_serializer: one filtering and one non-filtering
// instance (LANES=2, DEPTH=4) share lane data; a negedge monitor checks every presented entry.
`timescale 1ns/1ps
module tb_debug_wb_serializer;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } entry_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  valid_a = '0, valid_b = '0;
  logic [63:0] in_pc = '0, in_wdata = '0;
  logic [7:0]  in_wen = '0;
  logic [9:0]  in_wnum = '0;

  logic        ready_a, ready_b, ovf_a, ovf_b;
  logic [31:0] pc_a, pc_b, wdata_a, wdata_b;
  logic [3:0]  wen_a, wen_b;
  logic [4:0]  wnum_a, wnum_b;
  logic [2:0]  occ_a, occ_b;

  int n_checks = 0;
  int n_errors = 0;
  entry_t exp_a[$];
  entry_t exp_b[$];
  entry_t mon_a, mon_b;

  always #5 clk = ~clk;

  debug_wb_serializer #(.LANES(2), .DEPTH(4), .DROP_NOWRITE(1)) u_drop (
    .clk(clk), .resetn(resetn), .in_valid(valid_a), .in_pc(in_pc), .in_wen(in_wen),
    .in_wnum(in_wnum), .in_wdata(in_wdata), .in_ready(ready_a), .debug_wb_pc(pc_a),
    .debug_wb_rf_wen(wen_a), .debug_wb_rf_wnum(wnum_a), .debug_wb_rf_wdata(wdata_a),
    .occupancy(occ_a), .overflow(ovf_a));

  debug_wb_serializer #(.LANES(2), .DEPTH(4), .DROP_NOWRITE(0)) u_keep (
    .clk(clk), .resetn(resetn), .in_valid(valid_b), .in_pc(in_pc), .in_wen(in_wen),
    .in_wnum(in_wnum), .in_wdata(in_wdata), .in_ready(ready_b), .debug_wb_pc(pc_b),
    .debug_wb_rf_wen(wen_b), .debug_wb_rf_wnum(wnum_b), .debug_wb_rf_wdata(wdata_b),
    .occupancy(occ_b), .overflow(ovf_b));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic [31:0] pc, input logic [3:0] wen,
                          input logic [4:0] wnum, input logic [31:0] wdata);
    in_pc[32*i +: 32]    = pc;
    in_wen[4*i +: 4]     = wen;
    in_wnum[5*i +: 5]    = wnum;
    in_wdata[32*i +: 32] = wdata;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    resetn  = 1'b0;
    valid_a = '0;
    valid_b = '0;
    exp_a.delete();
    exp_b.delete();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 30 && (exp_a.size() != 0 || exp_b.size() != 0); k++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({name, "_drain_a"}, exp_a.size(), 0);
    check({name, "_drain_b"}, exp_b.size(), 0);
  endtask

  // Monitor: any presented entry must match the head of its instance's expected queue.
  always @(negedge clk) begin
    if (wen_a != '0) begin
      if (exp_a.size() == 0) check("a_unexpected", {pc_a, wen_a, wnum_a, wdata_a}, '0);
      else begin
        mon_a = exp_a.pop_front();
        check("a_entry", {pc_a, wen_a, wnum_a, wdata_a}, mon_a);
      end
    end
    if (wen_b != '0) begin
      if (exp_b.size() == 0) check("b_unexpected", {pc_b, wen_b, wnum_b, wdata_b}, '0);
      else begin
        mon_b = exp_b.pop_front();
        check("b_entry", {pc_b, wen_b, wnum_b, wdata_b}, mon_b);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc;

    // 1. Reset held with random inputs, then release.
    for (int k = 0; k < 3; k++) begin
      in_pc    = {$urandom, $urandom};
      in_wdata = {$urandom, $urandom};
      in_wen   = 8'($urandom);
      in_wnum  = 10'($urandom);
      valid_a  = 2'($urandom_range(0, 3));
      valid_b  = 2'($urandom_range(0, 3));
      @(negedge clk);
      check("rst_out_a", {pc_a, wen_a, wnum_a, wdata_a}, '0);
      check("rst_out_b", {pc_b, wen_b, wnum_b, wdata_b}, '0);
      check("rst_occ_ovf_a", {occ_a, ovf_a}, '0);
      check("rst_ready_a", ready_a, 1);
      check("rst_ready_b", ready_b, 1);
    end
    valid_a = '0;
    valid_b = '0;
    resetn  = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_out_a", {pc_a, wen_a, wnum_a, wdata_a}, '0);
      check("post_rst_occ_a", occ_a, 0);
    end

    // 2. Single commit on lane 0.
    reset_dut();
    set_lane(0, 32'hbfc00000, 4'hf, 5'd2, 32'h1234);
    valid_a = 2'b01;
    exp_a.push_back('{32'hbfc00000, 4'hf, 5'd2, 32'h1234});
    @(negedge clk);
    valid_a = '0;
    check("single_no_bypass", wen_a, 0);
    check("single_occ", occ_a, 1);
    @(negedge clk);
    check("single_out", {pc_a, wen_a, wnum_a, wdata_a},
          {32'hbfc00000, 4'hf, 5'd2, 32'h1234});
    @(negedge clk);
    check("single_after", wen_a, 0);

    // 3. Dual commit ordering.
    set_lane(0, 32'hbfc00010, 4'hf, 5'd3, 32'haaaa0010);
    set_lane(1, 32'hbfc00014, 4'h3, 5'd4, 32'haaaa0014);
    valid_a = 2'b11;
    exp_a.push_back('{32'hbfc00010, 4'hf, 5'd3, 32'haaaa0010});
    exp_a.push_back('{32'hbfc00014, 4'h3, 5'd4, 32'haaaa0014});
    @(negedge clk);
    valid_a = '0;
    @(negedge clk);
    check("dual_first", pc_a, 32'hbfc00010);
    @(negedge clk);
    check("dual_second", pc_a, 32'hbfc00014);
    drain("dual");

    // 4. Filtering: lane 0 writes x0, lane 1 writes x5.
    set_lane(0, 32'hbfc00020, 4'hf, 5'd0, 32'h11);
    set_lane(1, 32'hbfc00024, 4'hf, 5'd5, 32'h22);
    valid_a = 2'b11;
    valid_b = 2'b11;
    exp_a.push_back('{32'hbfc00024, 4'hf, 5'd5, 32'h22});
    exp_b.push_back('{32'hbfc00020, 4'hf, 5'd0, 32'h11});
    exp_b.push_back('{32'hbfc00024, 4'hf, 5'd5, 32'h22});
    @(negedge clk);
    valid_a = '0;
    valid_b = '0;
    check("filt_occ_a", occ_a, 1);
    check("filt_occ_b", occ_b, 2);
    @(negedge clk);
    check("filt_occ_a2", occ_a, 0);
    check("filt_occ_b2", occ_b, 1);
    check("filt_wnum_a", wnum_a, 5);
    check("filt_wnum_b", wnum_b, 0);
    drain("filt");

    // 5a. Saturation obeying in_ready.
    reset_dut();
    pc = 32'hbfc01000;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      check("sat_occ", occ_a, (k == 0) ? 0 : ((k % 2) ? 2 : 3));
      check("sat_ready", ready_a, (k == 0 || (k % 2) == 1) ? 1 : 0);
      if (ready_a) begin
        set_lane(0, pc, 4'hf, 5'd7, pc ^ 32'h5a5a0000);
        set_lane(1, pc + 4, 4'hf, 5'd8, (pc + 4) ^ 32'h5a5a0000);
        exp_a.push_back('{pc, 4'hf, 5'd7, pc ^ 32'h5a5a0000});
        exp_a.push_back('{pc + 32'd4, 4'hf, 5'd8, (pc + 32'd4) ^ 32'h5a5a0000});
        pc = pc + 8;
        valid_a = 2'b11;
      end else begin
        valid_a = '0;
      end
    end
    @(negedge clk);
    valid_a = '0;
    check("sat_no_ovf", ovf_a, 0);
    drain("sat");

    // 5b. Ignoring in_ready: the pair issued in cycle 2 is dropped.
    reset_dut();
    pc = 32'hbfc01800;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      check("ovf_flag", ovf_a, (k == 3) ? 1 : 0);
      if (k == 2) check("ovf_blocked_ready", ready_a, 0);
      set_lane(0, pc, 4'hf, 5'd9, pc);
      set_lane(1, pc + 4, 4'hf, 5'd10, pc + 4);
      valid_a = 2'b11;
      if (k != 2) begin
        exp_a.push_back('{pc, 4'hf, 5'd9, pc});
        exp_a.push_back('{pc + 32'd4, 4'hf, 5'd10, pc + 32'd4});
      end
      pc = pc + 8;
    end
    @(negedge clk);
    valid_a = '0;
    check("ovf_sticky", ovf_a, 1);
    drain("ovf");
    check("ovf_still_sticky", ovf_a, 1);

    // 6. Reset mid-stream with 3 entries buffered.
    reset_dut();
    check("mid_ovf_cleared", ovf_a, 0);
    set_lane(0, 32'hbfc02000, 4'hf, 5'd11, 32'h1);
    set_lane(1, 32'hbfc02004, 4'hf, 5'd12, 32'h2);
    valid_a = 2'b11;
    exp_a.push_back('{32'hbfc02000, 4'hf, 5'd11, 32'h1});
    @(negedge clk);
    set_lane(0, 32'hbfc02008, 4'hf, 5'd13, 32'h3);
    set_lane(1, 32'hbfc0200c, 4'hf, 5'd14, 32'h4);
    @(negedge clk);
    valid_a = '0;
    check("mid_occ", occ_a, 3);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_out", {pc_a, wen_a, wnum_a, wdata_a}, '0);
    check("mid_rst_occ", occ_a, 0);
    check("mid_rst_ready", ready_a, 1);
    #1 resetn = 1'b1;
    repeat (6) @(negedge clk);
    check("mid_queue_empty", exp_a.size(), 0);
    check("mid_occ_after", occ_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
